// File: rtl/multi_edge_detect.sv
//------------------------------------------------------------------------------
// multi_edge_detect
//   N-channel glitch-filtered edge detector with rising/falling/any pulses,
//   sticky edge flags and saturating per-channel edge counters.
//   Optional macro: EDGE_SYNC_EN adds a 2-flop input synchronizer per channel.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multi_edge_detect #(
  parameter int N          = 4,
  parameter int FILTER_LEN = 3,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       a_i,
  input  logic [N-1:0]       clr_i,
  output logic [N-1:0]       rising_edge_o,
  output logic [N-1:0]       falling_edge_o,
  output logic [N-1:0]       any_edge_o,
  output logic [N-1:0]       level_o,
  output logic [N-1:0]       sticky_rise_o,
  output logic [N-1:0]       sticky_fall_o,
  output logic [N*CNT_W-1:0] edge_cnt_o
);

  localparam int               S_W     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [S_W-1:0]   S_LAST  = S_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0] x_w;

`ifdef EDGE_SYNC_EN
  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= a_i;
      sync2_q <= sync1_q;
    end
  end

  assign x_w = sync2_q;
`else
  assign x_w = a_i;
`endif

  for (genvar n = 0; n < N; n++) begin : g_ch
    logic             f_q, f_d;
    logic [S_W-1:0]   s_q, s_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             srise_q, srise_d;
    logic             sfall_q, sfall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_w;

    // s counts consecutive samples disagreeing with the accepted level
    always_comb begin
      f_d    = f_q;
      s_d    = s_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (x_w[n] == f_q) begin
        s_d = '0;
      end else if (s_q == S_LAST) begin
        f_d    = x_w[n];
        s_d    = '0;
        rise_d = x_w[n];
        fall_d = ~x_w[n];
      end else begin
        s_d = s_q + 1'b1;
      end
    end

    assign edge_w = rise_d | fall_d;

    always_comb begin
      srise_d = rise_d | (srise_q & ~clr_i[n]);
      sfall_d = fall_d | (sfall_q & ~clr_i[n]);
      cnt_d   = cnt_q;
      if (clr_i[n]) begin
        cnt_d = edge_w ? CNT_W'(1) : '0;
      end else if (edge_w && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        f_q     <= 1'b0;
        s_q     <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        srise_q <= 1'b0;
        sfall_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        f_q     <= f_d;
        s_q     <= s_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        srise_q <= srise_d;
        sfall_q <= sfall_d;
        cnt_q   <= cnt_d;
      end
    end

    assign rising_edge_o[n]                = rise_q;
    assign falling_edge_o[n]               = fall_q;
    assign any_edge_o[n]                   = rise_q | fall_q;
    assign level_o[n]                      = f_q;
    assign sticky_rise_o[n]                = srise_q;
    assign sticky_fall_o[n]                = sfall_q;
    assign edge_cnt_o[n*CNT_W +: CNT_W]    = cnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_edge_detect.sv
//------------------------------------------------------------------------------
// tb_multi_edge_detect
//   Table vectors, directed corner sequences and random stimulus vs a model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_edge_detect;

  localparam int N  = 4;
  localparam int FL = 3;
  localparam int CW = 8;
  localparam int NR = 10;
`ifdef EDGE_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    a_i, clr_i;
  logic [N-1:0]    rise, fall, anye, level, srise, sfall;
  logic [N*CW-1:0] cnt;

  always #5 clk = ~clk;

  multi_edge_detect #(.N(N), .FILTER_LEN(FL), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .a_i            (a_i),
    .clr_i          (clr_i),
    .rising_edge_o  (rise),
    .falling_edge_o (fall),
    .any_edge_o     (anye),
    .level_o        (level),
    .sticky_rise_o  (srise),
    .sticky_fall_o  (sfall),
    .edge_cnt_o     (cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: history of filter-input samples per channel
  logic [N-1:0]    m_f, m_rise, m_fall, m_sr, m_sf;
  int              m_cnt [N];
  logic [FL-1:0]   m_hist [N];
  logic [N-1:0]    m_dq [$];
  int              obs_rise [N];
  int              obs_fall [N];

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] rise;
    logic [N-1:0] level;
    logic [7:0]   cnt0;
  } vec_t;

  vec_t         tbl [NR];
  vec_t         ev;
  logic [N-1:0] cur, ra, rc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] a, input logic [N-1:0] c, input logic r);
    logic [N-1:0] x;
    logic         acc;
    if (r) begin
      m_f = '0; m_rise = '0; m_fall = '0; m_sr = '0; m_sf = '0;
      m_dq.delete();
      for (int k = 0; k < SYNC; k++) m_dq.push_back('0);
      for (int n = 0; n < N; n++) begin
        m_cnt[n]  = 0;
        m_hist[n] = '0;
      end
    end else begin
      if (SYNC == 0) begin
        x = a;
      end else begin
        x = m_dq.pop_front();
        m_dq.push_back(a);
      end
      for (int n = 0; n < N; n++) begin
        m_hist[n] = {m_hist[n][FL-2:0], x[n]};
        // accept once the last FL samples all oppose the current level
        acc       = (m_hist[n] == {FL{~m_f[n]}});
        m_rise[n] = acc & ~m_f[n];
        m_fall[n] = acc & m_f[n];
        m_f[n]    = m_f[n] ^ acc;
        m_sr[n]   = m_rise[n] | (m_sr[n] & ~c[n]);
        m_sf[n]   = m_fall[n] | (m_sf[n] & ~c[n]);
        if (c[n]) m_cnt[n] = acc ? 1 : 0;
        else if (acc) m_cnt[n] = (m_cnt[n] + 1 > 2**CW - 1) ? 2**CW - 1 : m_cnt[n] + 1;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] a, input logic [N-1:0] c, input logic r);
    logic [N*CW-1:0] ecnt;
    a_i   = a;
    clr_i = c;
    reset = r;
    @(posedge clk);
    model_edge(a, c, r);
    #1;
    for (int n = 0; n < N; n++) ecnt[n*CW +: CW] = CW'(m_cnt[n]);
    chk("m_rise",  rise,  m_rise);
    chk("m_fall",  fall,  m_fall);
    chk("m_any",   anye,  m_rise | m_fall);
    chk("m_level", level, m_f);
    chk("m_srise", srise, m_sr);
    chk("m_sfall", sfall, m_sf);
    chk("m_cnt",   cnt,   ecnt);
    for (int n = 0; n < N; n++) begin
      obs_rise[n] += int'(rise[n]);
      obs_fall[n] += int'(fall[n]);
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{a:4'b0001, rise:4'b0000, level:4'b0000, cnt0:8'd0};
    tbl[1] = '{a:4'b0001, rise:4'b0000, level:4'b0000, cnt0:8'd0};
    tbl[2] = '{a:4'b0001, rise:4'b0001, level:4'b0001, cnt0:8'd1};
    tbl[3] = '{a:4'b0011, rise:4'b0000, level:4'b0001, cnt0:8'd1};
    tbl[4] = '{a:4'b0011, rise:4'b0000, level:4'b0001, cnt0:8'd1};
    tbl[5] = '{a:4'b0001, rise:4'b0000, level:4'b0001, cnt0:8'd1};
    tbl[6] = '{a:4'b0011, rise:4'b0000, level:4'b0001, cnt0:8'd1};
    tbl[7] = '{a:4'b0001, rise:4'b0000, level:4'b0001, cnt0:8'd1};
    tbl[8] = '{a:4'b0001, rise:4'b0000, level:4'b0001, cnt0:8'd1};
    tbl[9] = '{a:4'b0001, rise:4'b0000, level:4'b0001, cnt0:8'd1};

    a_i = '0; clr_i = '0; reset = 1'b1;
    @(negedge clk);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    chk("reset_level", level, 0);
    chk("reset_cnt",   cnt,   0);
    chk("reset_pulse", {rise, fall, srise, sfall}, 0);

    // Ch0 clean rise, ch1 short glitches
    for (int i = 0; i < NR + SYNC; i++) begin
      step(tbl[(i < NR) ? i : NR - 1].a, '0, 1'b0);
      if (i < SYNC) ev = '{a:'0, rise:'0, level:'0, cnt0:'0};
      else          ev = tbl[i - SYNC];
      chk("tbl_rise",  rise,       ev.rise);
      chk("tbl_level", level,      ev.level);
      chk("tbl_srise", srise,      ev.level);
      chk("tbl_cnt0",  cnt[7:0],   ev.cnt0);
      chk("tbl_cnt1",  cnt[15:8],  0);
    end

    // Clear coinciding with a falling pulse on ch0
    cur = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      cur[0] = ~cur[0];
      for (int h = 0; h < 5; h++) step(cur, '0, 1'b0);
    end
    chk("pre_clr_cnt0", cnt[7:0], 7);
    cur[0] = 1'b0;
    for (int h = 0; h < FL - 1 + SYNC; h++) step(cur, '0, 1'b0);
    step(cur, 4'b0001, 1'b0);
    chk("clr_fall0",  fall[0],  1);
    chk("clr_sfall0", sfall[0], 1);
    chk("clr_srise0", srise[0], 0);
    chk("clr_cnt0",   cnt[7:0], 1);
    step(cur, '0, 1'b0);
    chk("fall_width", fall[0], 0);

    // Saturation on ch2
    for (int n = 0; n < N; n++) begin obs_rise[n] = 0; obs_fall[n] = 0; end
    for (int k = 0; k < 300; k++) begin
      cur[2] = ~cur[2];
      for (int h = 0; h < 5; h++) step(cur, '0, 1'b0);
    end
    for (int h = 0; h < 5; h++) step(cur, '0, 1'b0);
    chk("sat_cnt2",  cnt[23:16],  255);
    chk("sat_rise2", obs_rise[2], 150);
    chk("sat_fall2", obs_fall[2], 150);

    // Reset landing on the edge that would complete ch3's filter
    cur = 4'b1000;
    for (int h = 0; h < FL - 1 + SYNC; h++) step(cur, '0, 1'b0);
    step(cur, '0, 1'b1);
    chk("rst_mid_out", {rise, fall, level, srise, sfall}, 0);
    chk("rst_mid_cnt", cnt, 0);
    for (int h = 1; h <= FL + SYNC; h++) begin
      step(cur, '0, 1'b0);
      chk("post_rst_rise3", rise, (h == FL + SYNC) ? 4'b1000 : 4'b0000);
    end
    chk("post_rst_cnt3", cnt[31:24], 1);

    // Random stimulus against the model
    ra = cur;
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < N; n++) begin
        if ($urandom_range(5) == 0) ra[n] = ~ra[n];
        rc[n] = ($urandom_range(15) == 0);
      end
      step(ra, rc, ($urandom_range(399) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_edge_detect.md
# multi_edge_detect

Parametrised, multi-channel successor to the single-bit edge detector. For each of N input channels it removes glitches with a stability filter and emits single-cycle rising, falling and any-edge pulses. It also keeps sticky edge flags and saturating edge counters that software/host logic clears per channel. It sits between raw level inputs (buttons, status lines, handshake wires) and control FSMs that need clean one-shot events.

## Interface
Parameters:
- N, 4, number of independent channels (≥1)
- FILTER_LEN, 3, consecutive cycles a new level must be held before acceptance (≥1; 1 = no filtering)
- CNT_W, 8, width of each per-channel edge counter (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- a_i  in  N  raw level inputs, one bit per channel
- clr_i  in  N  per-channel clear of sticky flags and counter
- rising_edge_o  out  N  1-cycle pulse on accepted 0→1
- falling_edge_o  out  N  1-cycle pulse on accepted 1→0
- any_edge_o  out  N  rising_edge_o | falling_edge_o
- level_o  out  N  filtered (accepted) level
- sticky_rise_o  out  N  set by rising pulse, held until clr_i/reset
- sticky_fall_o  out  N  set by falling pulse, held until clr_i/reset
- edge_cnt_o  out  N*CNT_W  per-channel accepted-edge count; channel n at [n*CNT_W +: CNT_W]

## Operation
- Channels are fully independent; the per-channel description below applies to every n.
- State per channel: filtered level f (level_o), stability counter s (width clog2(FILTER_LEN), min 1), sticky bits, edge counter.
- Each clk, with x = sampled input:
  - x == f: s <= 0, no pulse.
  - x != f and s == FILTER_LEN-1: f <= x, s <= 0, rising_edge_o <= x, falling_edge_o <= ~x for one cycle.
  - x != f otherwise: s <= s+1.
- A glitch shorter than FILTER_LEN cycles resets s on return and is never reported.
- Pulse outputs are registered and deassert the cycle after assertion. Back-to-back pulses on one channel are impossible when FILTER_LEN ≥ 2.
- Sticky: set on the corresponding pulse, cleared by clr_i[n]. When set and clear coincide, set wins.
- Counter: +1 per accepted edge (either direction). It saturates at 2^CNT_W-1 and never wraps. clr_i[n] loads 0. clr_i[n] together with an edge in the same cycle loads 1.
- clr_i does not affect f, s or the pulse outputs.

## Timing
- Reset (synchronous, active-high) drives every output low: f=0, s=0, pulses=0, sticky=0, counters=0. Synchronizer flops also reset to 0.
- Reset mid-filter discards partial s. An a_i held at 1 through reset release produces a rising pulse FILTER_LEN cycles after release (plus sync latency). That edge is counted.
- Latency without sync: an a_i change sampled at edge k makes f change and the pulse appear after edge k+FILTER_LEN-1. The pulse is high for exactly one cycle.
- Latency with EDGE_SYNC_EN: +2 cycles.
- sticky/counter update on the same edge that raises the pulse. They are visible in the same cycle as the pulse.

## Configuration
- EDGE_SYNC_EN defined: each a_i bit passes through a 2-flop synchronizer (reset to 0) before the filter. Safe for asynchronous inputs; adds 2 cycles of latency.
- EDGE_SYNC_EN undefined: a_i is sampled directly and must be synchronous to clk; there is no added latency.

## Test plan
- N=4, FILTER_LEN=3, no sync. After reset, ch0 a_i 0→1 held 10 cycles. Required: rising_edge_o[0] single pulse 3 edges after first sample, level_o[0]=1, sticky_rise_o[0]=1, count=1. Other channels stay quiet.
- Ch1 glitches high for 2 cycles, then high for 1 cycle. Required: no pulses, level_o[1]=0, count=0.
- Ch2 toggled with 5-cycle hold 300 times with CNT_W=8. Required: count saturates at 255 and holds. One rising and one falling pulse per full period.
- clr_i[0] asserted in the same cycle as a falling pulse on ch0 (count was 7). Required: sticky_fall_o[0]=1, count=1, sticky_rise_o[0]=0.
- Reset asserted 1 cycle before a filter would complete on ch3. Required: no pulse, all outputs 0. With a_i[3] still 1 after release, a rising pulse occurs 3 cycles later.
- EDGE_SYNC_EN defined: repeat the first scenario. Required: pulse 2 cycles later than without the macro, width still 1 cycle.
